ntt_addr_sequencer: RTL and testbench
=====================================

# ntt_addr_sequencer

Parametrised address and twiddle-index sequencer for the NTT/INTT butterfly datapath. On a start pulse it emits one butterfly descriptor per accepted cycle: the operand addresses, the twiddle index and the stage number. It supports forward Cooley-Tukey, inverse Gentleman-Sande and point-wise passes for polynomials of length N = 2^LOG_N. It sits between the polynomial RAM controller and the butterfly pipeline. It adds a start/busy/done handshake, downstream back-pressure, and a configurable number of idle gap cycles between stages so the pipeline can drain.

## Interface
- LOG_N, 8: log2 of the polynomial length; legal range 2..12.
- STAGE_GAP, 0: idle cycles inserted between consecutive stages; legal range 0..15.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begins a pass; sampled only in IDLE.
- mode  in  2  pass type, sampled with start: 00 forward, 01 inverse, 10 point-wise, 11 reserved (treated as forward).
- ready  in  1  the butterfly pipeline accepts the current descriptor.
- valid  out  1  the descriptor is valid.
- addr_a  out  LOG_N  first operand address.
- addr_b  out  LOG_N  second operand address.
- tw_idx  out  LOG_N  twiddle-table index.
- stage  out  4  current stage number.
- last  out  1  this descriptor is the final one of the pass.
- busy  out  1  a pass is in progress.
- done  out  1  one-cycle pulse when a pass completes.

## Operation
- FSM states:
  - IDLE: on start, go to RUN.
  - RUN: on a transfer of the final descriptor of a stage:
    - final stage: go to IDLE.
    - otherwise, with STAGE_GAP>0: go to GAP.
    - otherwise: stay in RUN and advance the stage.
  - GAP: counts STAGE_GAP cycles, then returns to RUN.
- Transfer = valid && ready. While valid && !ready, every output holds its value.
- Counters:
  - stage counter s.
  - butterfly counter k, width LOG_N-1, range 0..N/2-1.
  - In point-wise mode k has width LOG_N and range 0..N-1.
- Forward mode (LOG_N stages, s = 0..LOG_N-1):
  - distance d = N >> (s+1).
  - group index g = k >> log2(d).
  - addr_a = k with a zero bit inserted at bit position log2(d).
  - addr_b = addr_a + d.
  - tw_idx = (N/(2d)) + g.
- Inverse mode (LOG_N stages, s = 0..LOG_N-1):
  - d = 1 << s.
  - addr_a, addr_b and g are computed as in forward mode.
  - tw_idx = (N/(2d)) + g, indexing the inverse table.
- Point-wise mode (one stage, stage=0):
  - addr_a = addr_b = k.
  - tw_idx = 0.
- All address and index arithmetic is modulo 2^LOG_N; no result may exceed N-1.
- last is asserted on the final descriptor of the final stage only.
- start while busy is ignored; mode is not re-sampled mid-pass.
- rst at any cycle:
  - FSM returns to IDLE.
  - All counters clear.
  - Any in-flight pass is abandoned without a done pulse.

## Timing
- Reset values: valid=0, busy=0, done=0, last=0, addr_a=0, addr_b=0, tw_idx=0, stage=0.
- All outputs are registered.
- start accepted at cycle t: busy=1 and valid=1 with the first descriptor at cycle t+1.
- With ready held high, descriptors are contiguous within a stage.
- Between stages there are exactly STAGE_GAP cycles with valid=0. busy stays 1 during the gap.
- Pass length with ready high:
  - forward/inverse: LOG_N·N/2 + (LOG_N-1)·STAGE_GAP cycles.
  - point-wise: N cycles.
- Completion: the final transfer occurs at cycle u. At cycle u+1, done=1 for exactly one cycle, busy=0 and valid=0.
- A new start is accepted at the earliest at cycle u+1; it is ignored if asserted in the same cycle as the final transfer.
- ready is ignored while valid=0.

## Structure
- Shared package ntt_pkg:
  - mode encodings MODE_FWD, MODE_INV, MODE_PW.
  - FSM state encoding IDLE, RUN, GAP.
  - LOG_N range constants.
- One combinational sub-module, ntt_addr_map. Inputs: k, s, mode. Outputs: addr_a, addr_b, tw_idx. It performs the zero-bit insertion and twiddle computation.
- The top level holds the FSM, counters and output registers.

## Test plan
- Forward pass, LOG_N=3, STAGE_GAP=0, ready=1. Required (a,b,tw) sequence:
  - stage 0: (0,4,1) (1,5,1) (2,6,1) (3,7,1)
  - stage 1: (0,2,2) (1,3,2) (4,6,3) (5,7,3)
  - stage 2: (0,1,4) (2,3,5) (4,5,6) (6,7,7)
  - last on the 12th descriptor; done on the following cycle.
- Inverse pass, LOG_N=3:
  - stage 0: (0,1,4) (2,3,5) (4,5,6) (6,7,7)
  - stage 2: (0,4,1) (1,5,1) (2,6,1) (3,7,1)
- STAGE_GAP=3, forward, LOG_N=3, ready=1 -> exactly 3 valid=0 cycles after descriptors 4 and 8; total 18 cycles from the first valid to done.
- Random ready back-pressure on a forward LOG_N=8 pass -> the accepted sequence is identical to the ready=1 run (1024 descriptors) and the outputs are stable whenever valid && !ready.
- Point-wise, LOG_N=4 -> 16 descriptors with a=b=0..15 and tw=0.
- rst asserted on descriptor 5 of a forward pass -> next cycle valid=0, busy=0, no done pulse. A start pulse after reset restarts the pass from (0,N/2,1).

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types for the NTT address sequencer.
// Pass modes, FSM states and parameter limits.
package ntt_pkg;

  typedef enum logic [1:0] {
    MODE_FWD = 2'b00,
    MODE_INV = 2'b01,
    MODE_PW  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    GAP  = 2'b10
  } state_e;

  localparam int LOG_N_MIN     = 2;
  localparam int LOG_N_MAX     = 12;
  localparam int STAGE_GAP_MAX = 15;

  // The reserved encoding runs as a forward pass
  function automatic mode_e norm_mode(input logic [1:0] m);
    mode_e r;
    unique case (m)
      2'b01:   r = MODE_INV;
      2'b10:   r = MODE_PW;
      default: r = MODE_FWD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ntt_addr_map.sv
// Butterfly counter to operand address / twiddle index map.
// Pure combinational; one instance per sequencer.
module ntt_addr_map
  import ntt_pkg::*;
#(
  parameter int LOG_N = 8
) (
  input  logic [LOG_N-1:0] k,
  input  logic [3:0]       s,
  input  mode_e            mode,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-1:0] tw_idx
);

  localparam logic [3:0]       P_TOP = 4'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE   = LOG_N'(1);

  logic [3:0]       p;
  logic [LOG_N-1:0] d;
  logic [LOG_N-1:0] lo_mask;
  logic [LOG_N-1:0] ins;
  logic [LOG_N-1:0] g;
  logic [LOG_N-1:0] base;

  // p = log2 of the butterfly distance; base = N/(2d)
  always_comb begin
    p       = (mode == MODE_INV) ? s : P_TOP - s;
    d       = ONE << p;
    lo_mask = d - ONE;
    ins     = ((k & ~lo_mask) << 1) | (k & lo_mask);
    g       = k >> p;
    base    = ONE << (P_TOP - p);
    addr_a  = ins;
    addr_b  = ins + d;
    tw_idx  = base + g;
    if (mode == MODE_PW) begin
      addr_a = k;
      addr_b = k;
      tw_idx = '0;
    end
  end

endmodule

// File: rtl/ntt_addr_sequencer.sv
// NTT/INTT butterfly descriptor sequencer.
// Start/busy/done handshake, back-pressure, inter-stage gaps.
module ntt_addr_sequencer
  import ntt_pkg::*;
#(
  parameter int LOG_N     = 8,
  parameter int STAGE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             ready,
  output logic             valid,
  output logic [LOG_N-1:0] addr_a,
  output logic [LOG_N-1:0] addr_b,
  output logic [LOG_N-1:0] tw_idx,
  output logic [3:0]       stage,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0]       P_TOP    = 4'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE      = LOG_N'(1);
  localparam logic [LOG_N-1:0] K_BF_MAX = {1'b0, {(LOG_N-1){1'b1}}};
  localparam bit               HAS_GAP  = STAGE_GAP > 0;
  localparam logic [3:0]       GAP_INIT =
    HAS_GAP ? 4'(STAGE_GAP - 1) : 4'd0;

  state_e           state;
  mode_e            mode_r;
  mode_e            map_mode;
  logic [LOG_N-1:0] k;
  logic [LOG_N-1:0] nk;
  logic [LOG_N-1:0] k_max;
  logic [3:0]       s;
  logic [3:0]       ns;
  logic [3:0]       s_max;
  logic [3:0]       gap_cnt;
  logic             xfer;
  logic             k_end;
  logic             s_end;
  logic             nlast;
  logic [LOG_N-1:0] map_a;
  logic [LOG_N-1:0] map_b;
  logic [LOG_N-1:0] map_tw;

  assign stage = s;

  // Next descriptor position; outputs are loaded from its mapping
  always_comb begin
    xfer     = valid && ready;
    k_max    = (mode_r == MODE_PW) ? '1 : K_BF_MAX;
    s_max    = (mode_r == MODE_PW) ? 4'd0 : P_TOP;
    k_end    = (k == k_max);
    s_end    = (s == s_max);
    map_mode = mode_r;
    nk       = k + ONE;
    ns       = s;
    nlast    = 1'b0;
    if (state == IDLE) begin
      map_mode = norm_mode(mode);
      nk       = '0;
      ns       = '0;
    end else if (k_end) begin
      nk = '0;
      ns = s + 4'd1;
    end else begin
      nlast = s_end && (nk == k_max);
    end
  end

  ntt_addr_map #(
    .LOG_N(LOG_N)
  ) u_map (
    .k     (nk),
    .s     (ns),
    .mode  (map_mode),
    .addr_a(map_a),
    .addr_b(map_b),
    .tw_idx(map_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_r  <= MODE_FWD;
      k       <= '0;
      s       <= '0;
      gap_cnt <= '0;
      valid   <= 1'b0;
      addr_a  <= '0;
      addr_b  <= '0;
      tw_idx  <= '0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            mode_r <= map_mode;
            k      <= nk;
            s      <= ns;
            valid  <= 1'b1;
            busy   <= 1'b1;
            addr_a <= map_a;
            addr_b <= map_b;
            tw_idx <= map_tw;
            last   <= nlast;
          end
        end
        RUN: begin
          if (xfer) begin
            if (k_end && s_end) begin
              state <= IDLE;
              k     <= '0;
              s     <= '0;
              valid <= 1'b0;
              busy  <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
            end else begin
              k      <= nk;
              s      <= ns;
              addr_a <= map_a;
              addr_b <= map_b;
              tw_idx <= map_tw;
              last   <= nlast;
              if (k_end && HAS_GAP) begin
                state   <= GAP;
                valid   <= 1'b0;
                gap_cnt <= GAP_INIT;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= RUN;
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_addr_sequencer.sv
// Bench for ntt_addr_sequencer: descriptor-list model and
// per-cycle compare over four parameter sets.
module tb_ntt_addr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_w;
  logic [3:0] ready_w;
  logic [7:0] mode_w;
  logic [3:0] valid_w;
  logic [3:0] last_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;
  logic [15:0] stage_w;
  logic [2:0] a0, b0, t0;
  logic [2:0] a1, b1, t1;
  logic [7:0] a2, b2, t2;
  logic [3:0] a3, b3, t3;

  always #5 clk = ~clk;

  ntt_addr_sequencer #(.LOG_N(3), .STAGE_GAP(0)) u0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .mode(mode_w[1:0]),
    .ready(ready_w[0]), .valid(valid_w[0]), .addr_a(a0), .addr_b(b0),
    .tw_idx(t0), .stage(stage_w[3:0]), .last(last_w[0]),
    .busy(busy_w[0]), .done(done_w[0]));

  ntt_addr_sequencer #(.LOG_N(3), .STAGE_GAP(3)) u1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .mode(mode_w[3:2]),
    .ready(ready_w[1]), .valid(valid_w[1]), .addr_a(a1), .addr_b(b1),
    .tw_idx(t1), .stage(stage_w[7:4]), .last(last_w[1]),
    .busy(busy_w[1]), .done(done_w[1]));

  ntt_addr_sequencer #(.LOG_N(8), .STAGE_GAP(0)) u2 (
    .clk(clk), .rst(rst), .start(start_w[2]), .mode(mode_w[5:4]),
    .ready(ready_w[2]), .valid(valid_w[2]), .addr_a(a2), .addr_b(b2),
    .tw_idx(t2), .stage(stage_w[11:8]), .last(last_w[2]),
    .busy(busy_w[2]), .done(done_w[2]));

  ntt_addr_sequencer #(.LOG_N(4), .STAGE_GAP(1)) u3 (
    .clk(clk), .rst(rst), .start(start_w[3]), .mode(mode_w[7:6]),
    .ready(ready_w[3]), .valid(valid_w[3]), .addr_a(a3), .addr_b(b3),
    .tw_idx(t3), .stage(stage_w[15:12]), .last(last_w[3]),
    .busy(busy_w[3]), .done(done_w[3]));

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
    int gap;
  } desc_t;

  desc_t q[$];
  int checks = 0;
  int errors = 0;
  int sv, sa, sb, stw, sst, slst, sbsy, sdn;

  int fwd3[36] = '{0,4,1, 1,5,1, 2,6,1, 3,7,1,
                   0,2,2, 1,3,2, 4,6,3, 5,7,3,
                   0,1,4, 2,3,5, 4,5,6, 6,7,7};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic samp(input int id);
    sv   = int'(valid_w[id]);
    slst = int'(last_w[id]);
    sbsy = int'(busy_w[id]);
    sdn  = int'(done_w[id]);
    sst  = int'(stage_w[id*4 +: 4]);
    case (id)
      0: begin sa = int'(a0); sb = int'(b0); stw = int'(t0); end
      1: begin sa = int'(a1); sb = int'(b1); stw = int'(t1); end
      2: begin sa = int'(a2); sb = int'(b2); stw = int'(t2); end
      default: begin sa = int'(a3); sb = int'(b3); stw = int'(t3); end
    endcase
  endtask

  // Expected descriptor list, enumerated group by group
  task automatic build(input int L, input int G, input int md);
    int n, d;
    desc_t e;
    n = 1 << L;
    q.delete();
    if (md == 2) begin
      for (int k = 0; k < n; k++) begin
        e = '{k, k, 0, 0, 0};
        q.push_back(e);
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        d = (md == 1) ? (1 << s) : (n >> (s + 1));
        for (int base = 0; base < n; base += 2 * d)
          for (int i = 0; i < d; i++) begin
            e.a   = base + i;
            e.b   = base + i + d;
            e.tw  = n / (2 * d) + base / (2 * d);
            e.st  = s;
            e.gap = (s > 0 && base == 0 && i == 0) ? G : 0;
            q.push_back(e);
          end
      end
    end
  endtask

  task automatic run_pass(input int id, input int L, input int G,
                          input int md, input int pct,
                          input int abort_at, output int cyc);
    int idx, gl, budget, last_i;
    bit rdy;
    build(L, G, md);
    last_i = q.size() - 1;
    @(negedge clk);
    start_w[id] = 1'b1;
    mode_w[id*2 +: 2] = 2'(md);
    ready_w[id] = 1'b0;
    @(negedge clk);
    idx = 0;
    gl = 0;
    cyc = 0;
    budget = q.size() * 20 + 100;
    while (idx < q.size()) begin
      samp(id);
      rdy = (pct >= 100) || ($urandom_range(0, 99) < pct);
      ready_w[id] = rdy;
      start_w[id] = 1'b1;
      mode_w[id*2 +: 2] = 2'($urandom_range(0, 3));
      if (gl > 0) begin
        chk("gap_valid", sv, 0);
        chk("gap_busy", sbsy, 1);
        gl--;
      end else begin
        chk("valid", sv, 1);
        chk($sformatf("addr_a[%0d]", idx), sa, q[idx].a);
        chk($sformatf("addr_b[%0d]", idx), sb, q[idx].b);
        chk($sformatf("tw_idx[%0d]", idx), stw, q[idx].tw);
        chk($sformatf("stage[%0d]", idx), sst, q[idx].st);
        chk($sformatf("last[%0d]", idx), slst, int'(idx == last_i));
        chk("busy", sbsy, 1);
        chk("done_early", sdn, 0);
        if (idx == abort_at) begin
          rst = 1'b1;
          start_w[id] = 1'b0;
          @(negedge clk);
          samp(id);
          chk("rst_valid", sv, 0);
          chk("rst_busy", sbsy, 0);
          chk("rst_done", sdn, 0);
          rst = 1'b0;
          @(negedge clk);
          samp(id);
          chk("rst_done_after", sdn, 0);
          chk("rst_valid_after", sv, 0);
          ready_w[id] = 1'b0;
          return;
        end
        if (rdy) begin
          idx++;
          if (idx < q.size()) gl = q[idx].gap;
        end
      end
      cyc++;
      @(negedge clk);
      if (cyc > budget) begin
        checks++;
        errors++;
        $display("FAIL timeout: %0d cycles without completing pass", cyc);
        break;
      end
    end
    samp(id);
    chk("done_pulse", sdn, 1);
    chk("done_busy", sbsy, 0);
    chk("done_valid", sv, 0);
    chk("done_last", slst, 0);
    start_w[id] = 1'b0;
    ready_w[id] = 1'b0;
    @(negedge clk);
    samp(id);
    chk("done_once", sdn, 0);
    chk("idle_busy", sbsy, 0);
    chk("idle_valid", sv, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start_w = '0;
    ready_w = '0;
    mode_w = '0;
    repeat (3) @(negedge clk);
    for (int id = 0; id < 4; id++) begin
      samp(id);
      chk("reset_valid", sv, 0);
      chk("reset_busy", sbsy, 0);
      chk("reset_done", sdn, 0);
      chk("reset_last", slst, 0);
      chk("reset_addr_a", sa, 0);
      chk("reset_addr_b", sb, 0);
      chk("reset_tw", stw, 0);
      chk("reset_stage", sst, 0);
    end
    rst = 1'b0;

    build(3, 0, 0);
    chk("model_fwd3_len", q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk("model_fwd3_a", q[i].a, fwd3[3*i]);
      chk("model_fwd3_b", q[i].b, fwd3[3*i+1]);
      chk("model_fwd3_tw", q[i].tw, fwd3[3*i+2]);
    end
    build(3, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("model_inv3_s0_a", q[i].a, fwd3[24 + 3*i]);
      chk("model_inv3_s0_tw", q[i].tw, fwd3[24 + 3*i + 2]);
      chk("model_inv3_s2_a", q[8+i].a, fwd3[3*i]);
      chk("model_inv3_s2_b", q[8+i].b, fwd3[3*i+1]);
      chk("model_inv3_s2_tw", q[8+i].tw, fwd3[3*i+2]);
    end
    build(8, 0, 0);
    chk("model_fwd8_len", q.size(), 1024);

    run_pass(0, 3, 0, 0, 100, -1, cyc);
    chk("fwd3_cycles", cyc, 12);
    run_pass(0, 3, 0, 1, 100, -1, cyc);
    chk("inv3_cycles", cyc, 12);
    run_pass(0, 3, 0, 3, 100, -1, cyc);
    run_pass(0, 3, 0, 0, 100, 4, cyc);
    run_pass(0, 3, 0, 0, 100, -1, cyc);
    run_pass(0, 3, 0, 1, 50, -1, cyc);

    run_pass(1, 3, 3, 0, 100, -1, cyc);
    chk("gap3_cycles", cyc, 18);
    run_pass(1, 3, 3, 1, 60, -1, cyc);

    run_pass(2, 8, 0, 0, 70, -1, cyc);
    run_pass(2, 8, 0, 1, 100, -1, cyc);
    chk("inv8_cycles", cyc, 1024);

    run_pass(3, 4, 1, 2, 100, -1, cyc);
    chk("pw4_cycles", cyc, 16);
    run_pass(3, 4, 1, 0, 100, -1, cyc);
    chk("fwd4_gap1_cycles", cyc, 35);
    run_pass(3, 4, 1, 2, 40, -1, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
